// File: rtl/i2c_serial_engine.sv
// Byte-level I2C slave: filtered SCL/SDA, START/STOP detection, address match, pointer and burst R/W.
// Optional feature macro: I2C_CLOCK_STRETCH_EN (stretches SCL around each read-byte load).
module i2c_serial_engine #(
    parameter logic [6:0]  DEV_ADDR = 7'h3C,
    parameter int unsigned DEB_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic [7:0] addr,
    output logic [7:0] dataIn,
    output logic       writeEn,
    input  logic [7:0] dataOut,
    output logic       busy
);
`ifdef I2C_CLOCK_STRETCH_EN
    localparam bit STRETCH_EN = 1'b1;
`else
    localparam bit STRETCH_EN = 1'b0;
`endif
    localparam logic [2:0] DEB_LAST = 3'(DEB_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, DEV, ACK_DEV, REG, ACK_REG, WR, ACK_WR, RD, RACK, STRETCH, WAIT_STOP
    } state_t;

    // Index 0 = SCL, index 1 = SDA
    logic [1:0]      sync1_q, sync2_q, filt_q, filt_p_q;
    logic [1:0][2:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            filt_q   <= '1;
            filt_p_q <= '1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= {sda_in, scl_in};
            sync2_q  <= sync1_q;
            filt_p_q <= filt_q;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DEB_LAST) begin
                    filt_q[i] <= sync2_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 3'd1;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_ev, stop_ev;
    assign scl_f    = filt_q[0];
    assign sda_f    = filt_q[1];
    assign scl_rise = scl_f & ~filt_p_q[0];
    assign scl_fall = ~scl_f & filt_p_q[0];
    assign start_ev = scl_f & filt_p_q[0] & filt_p_q[1] & ~sda_f;
    assign stop_ev  = scl_f & filt_p_q[0] & ~filt_p_q[1] & sda_f;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d, addr_q, addr_d, data_q, data_d;
    logic [1:0]  str_cnt_q, str_cnt_d;
    logic        sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
    logic        wen_q, wen_d, inc_q, inc_d, busy_q, busy_d;
    logic [7:0]  byte_in;
    logic        last_bit;

    assign byte_in  = {shift_q[6:0], sda_f};
    assign last_bit = (bit_cnt_q == 4'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (stop_ev) begin
            state_d = IDLE;
        end else if (start_ev) begin
            state_d = DEV;
        end else begin
            case (state_q)
                DEV:     if (scl_rise && last_bit)
                             state_d = (byte_in[7:1] == DEV_ADDR) ? ACK_DEV : WAIT_STOP;
                ACK_DEV: if (scl_fall && sda_oe_q)
                             state_d = shift_q[0] ? (STRETCH_EN ? STRETCH : RD) : REG;
                REG:     if (scl_rise && last_bit) state_d = ACK_REG;
                ACK_REG,
                ACK_WR:  if (scl_fall && sda_oe_q) state_d = WR;
                WR:      if (scl_rise && last_bit) state_d = ACK_WR;
                RD:      if (scl_fall && bit_cnt_q == 4'd8) state_d = RACK;
                RACK:    if (scl_rise && sda_f) state_d = WAIT_STOP;
                         else if (scl_fall) state_d = STRETCH_EN ? STRETCH : RD;
                STRETCH: if (str_cnt_q == 2'd0) state_d = RD;
                default: ;
            endcase
        end
    end

    // ACK states use sda_oe_q as the phase flag: first fall asserts, second fall releases and leaves.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        sda_oe_d  = sda_oe_q;
        scl_oe_d  = scl_oe_q;
        addr_d    = inc_q ? addr_q + 8'd1 : addr_q;
        data_d    = data_q;
        wen_d     = 1'b0;
        inc_d     = wen_q;
        busy_d    = busy_q;
        str_cnt_d = str_cnt_q;
        if (stop_ev || start_ev) begin
            sda_oe_d  = 1'b0;
            scl_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                DEV, REG, WR: if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = last_bit ? 4'd0 : bit_cnt_q + 4'd1;
                    if (last_bit) begin
                        if (state_q == DEV) busy_d = (byte_in[7:1] == DEV_ADDR);
                        if (state_q == REG) addr_d = byte_in;
                        if (state_q == WR) begin
                            data_d = byte_in;
                            wen_d  = 1'b1;
                        end
                    end
                end
                ACK_DEV, ACK_REG, ACK_WR: if (scl_fall) begin
                    sda_oe_d = ~sda_oe_q;
                    if (sda_oe_q && state_q == ACK_DEV && shift_q[0]) begin
                        if (STRETCH_EN) begin
                            scl_oe_d  = 1'b1;
                            str_cnt_d = 2'd2;
                        end else begin
                            shift_d   = dataOut;
                            sda_oe_d  = ~dataOut[7];
                            bit_cnt_d = '0;
                        end
                    end
                end
                RD: begin
                    if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
                    if (scl_fall)
                        sda_oe_d = (bit_cnt_q == 4'd8) ? 1'b0 : ~shift_q[3'd7 - bit_cnt_q[2:0]];
                end
                RACK: if (scl_rise && !sda_f) begin
                    addr_d = addr_q + 8'd1;
                end else if (scl_fall) begin
                    if (STRETCH_EN) begin
                        scl_oe_d  = 1'b1;
                        str_cnt_d = 2'd2;
                    end else begin
                        shift_d   = dataOut;
                        sda_oe_d  = ~dataOut[7];
                        bit_cnt_d = '0;
                    end
                end
                STRETCH: begin
                    str_cnt_d = str_cnt_q - 2'd1;
                    if (str_cnt_q == 2'd0) begin
                        scl_oe_d  = 1'b0;
                        shift_d   = dataOut;
                        sda_oe_d  = ~dataOut[7];
                        bit_cnt_d = '0;
                    end
                end
                WAIT_STOP: sda_oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
            scl_oe_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            wen_q     <= 1'b0;
            inc_q     <= 1'b0;
            busy_q    <= 1'b0;
            str_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            sda_oe_q  <= sda_oe_d;
            scl_oe_q  <= scl_oe_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wen_q     <= wen_d;
            inc_q     <= inc_d;
            busy_q    <= busy_d;
            str_cnt_q <= str_cnt_d;
        end
    end

    assign sda_oe  = sda_oe_q;
    assign scl_oe  = scl_oe_q;
    assign addr    = addr_q;
    assign dataIn  = data_q;
    assign writeEn = wen_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_serial_engine.sv
// Bench for i2c_serial_engine: bit-banged I2C master, register-file consumer model,
// and a writeEn scoreboard fed by the stimulus flow.
`timescale 1ns/1ps
module tb_i2c_serial_engine;
    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe, scl_oe, writeEn, busy;
    logic [7:0] addr, dataIn;
    logic [7:0] dataOut = 8'h00;
    logic       scl_in, sda_in;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] wr_exp[$];
    logic [15:0] exp_w;
    logic        oe_seen = 1'b0;

    always #5 clk = ~clk;

    assign scl_in = scl_m & ~scl_oe;
    assign sda_in = sda_m & ~sda_oe;

    always @(posedge clk) dataOut <= ~addr;

    i2c_serial_engine #(.DEV_ADDR(7'h3C), .DEB_LEN(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .scl_in (scl_in),
        .sda_in (sda_in),
        .sda_oe (sda_oe),
        .scl_oe (scl_oe),
        .addr   (addr),
        .dataIn (dataIn),
        .writeEn(writeEn),
        .dataOut(dataOut),
        .busy   (busy)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, {7'd0, act}, {7'd0, exp});
    endtask

    always @(negedge clk) begin
        if (rst_n && sda_oe) oe_seen = 1'b1;
        if (rst_n && writeEn) begin
            if (wr_exp.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_writeEn: got addr 0x%02h data 0x%02h, expected no write", addr, dataIn);
            end else begin
                exp_w = wr_exp.pop_front();
                chk("wr_addr", addr, exp_w[15:8]);
                chk("wr_data", dataIn, exp_w[7:0]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, input bit glitch, output logic s);
        tick(Q);
        sda_m = b;
        tick(Q);
        scl_m = 1'b1;
        tick(Q / 2);
        if (glitch) begin
            scl_m = 1'b0;
            tick(2);
            scl_m = 1'b1;
        end
        tick(Q / 2);
        s = sda_in;
        tick(Q);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        tick(Q);
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input int gbit, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], i == gbit, s);
        clock_bit(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        clock_bit(nack, 1'b0, s);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack, s;
        logic [7:0] d;

        tick(2);
        chkb("rst_sda_oe", sda_oe, 1'b0);
        chkb("rst_scl_oe", scl_oe, 1'b0);
        chk ("rst_addr", addr, 8'h00);
        chk ("rst_dataIn", dataIn, 8'h00);
        chkb("rst_writeEn", writeEn, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick(10);

        // Single write
        i2c_start();
        write_byte(8'h78, -1, ack); chkb("sw_ack_dev", ack, 1'b1);
        write_byte(8'h81, -1, ack); chkb("sw_ack_reg", ack, 1'b1);
        wr_exp.push_back({8'h81, 8'h01});
        write_byte(8'h01, -1, ack); chkb("sw_ack_wr", ack, 1'b1);
        chkb("sw_busy_on", busy, 1'b1);
        i2c_stop();
        chkb("sw_busy_off", busy, 1'b0);
        chk ("sw_addr_after", addr, 8'h82);

        // Burst write
        i2c_start();
        write_byte(8'h78, -1, ack); chkb("bw_ack_dev", ack, 1'b1);
        write_byte(8'h88, -1, ack); chkb("bw_ack_reg", ack, 1'b1);
        wr_exp.push_back({8'h88, 8'hAA});
        wr_exp.push_back({8'h89, 8'h55});
        write_byte(8'hAA, -1, ack); chkb("bw_ack_w0", ack, 1'b1);
        write_byte(8'h55, -1, ack); chkb("bw_ack_w1", ack, 1'b1);
        i2c_stop();
        chk("bw_addr_final", addr, 8'h8A);

        // Read with pointer wrap
        i2c_start();
        write_byte(8'h78, -1, ack); chkb("rd_ack_dev", ack, 1'b1);
        write_byte(8'hFF, -1, ack); chkb("rd_ack_reg", ack, 1'b1);
        i2c_start();
        write_byte(8'h79, -1, ack); chkb("rd_ack_devr", ack, 1'b1);
        read_byte(1'b0, d); chk("rd_byte0", d, 8'h00);
        read_byte(1'b0, d); chk("rd_byte1", d, 8'hFF);
        read_byte(1'b1, d); chk("rd_byte2", d, 8'hFE);
        tick(5);
        chk ("rd_addr_final", addr, 8'h01);
        chkb("rd_busy_waitstop", busy, 1'b1);
        chkb("rd_sda_released", sda_oe, 1'b0);
        i2c_stop();
        chkb("rd_busy_off", busy, 1'b0);

        // Address mismatch
        oe_seen = 1'b0;
        i2c_start();
        write_byte(8'hA0, -1, ack); chkb("mm_nack_dev", ack, 1'b0);
        write_byte(8'h12, -1, ack); chkb("mm_nack_b1", ack, 1'b0);
        chkb("mm_busy", busy, 1'b0);
        i2c_stop();
        chkb("mm_oe_never", oe_seen, 1'b0);

        // SCL glitch filtering mid-byte
        i2c_start();
        write_byte(8'h78, -1, ack); chkb("gl_ack_dev", ack, 1'b1);
        write_byte(8'h40, -1, ack); chkb("gl_ack_reg", ack, 1'b1);
        wr_exp.push_back({8'h40, 8'hC3});
        write_byte(8'hC3, 4, ack);  chkb("gl_ack_wr", ack, 1'b1);
        i2c_stop();

        // Async reset during a data byte
        i2c_start();
        write_byte(8'h78, -1, ack); chkb("rs_ack_dev", ack, 1'b1);
        write_byte(8'h10, -1, ack); chkb("rs_ack_reg", ack, 1'b1);
        for (int i = 7; i >= 5; i--) clock_bit(1'b1, 1'b0, s);
        tick(Q / 2);
        rst_n = 1'b0;
        #1;
        chkb("rs_sda_oe", sda_oe, 1'b0);
        chkb("rs_scl_oe", scl_oe, 1'b0);
        chk ("rs_addr", addr, 8'h00);
        chk ("rs_dataIn", dataIn, 8'h00);
        chkb("rs_writeEn", writeEn, 1'b0);
        chkb("rs_busy", busy, 1'b0);
        tick(3);
        rst_n = 1'b1;
        for (int i = 4; i >= 0; i--) clock_bit(1'b0, 1'b0, s);
        clock_bit(1'b1, 1'b0, s);
        i2c_stop();

        // Repeated START mid data byte
        i2c_start();
        write_byte(8'h78, -1, ack); chkb("rr_ack_dev", ack, 1'b1);
        write_byte(8'h20, -1, ack); chkb("rr_ack_reg", ack, 1'b1);
        for (int i = 7; i >= 5; i--) clock_bit(1'b1, 1'b0, s);
        i2c_start();
        write_byte(8'h78, -1, ack); chkb("rr_ack_dev2", ack, 1'b1);
        chkb("rr_busy", busy, 1'b1);
        write_byte(8'h30, -1, ack); chkb("rr_ack_reg2", ack, 1'b1);
        wr_exp.push_back({8'h30, 8'h5A});
        write_byte(8'h5A, -1, ack); chkb("rr_ack_wr", ack, 1'b1);
        i2c_stop();
        chk("rr_addr_final", addr, 8'h31);

        tick(20);
        vectors++;
        if (wr_exp.size() != 0) begin
            miscompares++;
            $display("FAIL pending_writes: got %0d writes missing, expected 0", wr_exp.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
